// File: rtl/lfsr_5_top.sv
// lfsr_5_top: serial pseudo-random bit source muxing a Fibonacci and a Galois
// 5-bit LFSR (x^5+x^2+1), alternating every SWITCH_LEN cycles.
// Optional build macro LFSR_STATE_OUT_EN exposes fib_state, gal_state and sel_out.
module lfsr_5_top #(
    parameter logic [4:0] SEED       = 5'b00001,
    parameter int         SWITCH_LEN = 31
) (
    input  logic       clkTop,
    input  logic       nrstTop,
    output logic       MUX_out
`ifdef LFSR_STATE_OUT_EN
    ,
    output logic [4:0] fib_state,
    output logic [4:0] gal_state,
    output logic       sel_out
`endif
);
    // An all-zero seed would lock both LFSRs, so it is replaced by 1.
    localparam logic [4:0] SEED_EFF = (SEED == 5'd0) ? 5'b00001 : SEED;
    localparam logic [4:0] CNT_LAST = 5'(SWITCH_LEN - 1);

    logic [4:0] fib_q, fib_d;
    logic [4:0] gal_q, gal_d;
    logic [4:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       wrap;

    // Next state: both LFSRs free-run; the phase counter flips sel on wrap.
    always_comb begin
        fib_d = {fib_q[3:0], fib_q[4] ^ fib_q[2]};
        gal_d = {gal_q[3:0], 1'b0} ^ (gal_q[4] ? 5'b00101 : 5'b00000);
        wrap  = (cnt_q == CNT_LAST);
        cnt_d = wrap ? 5'd0 : cnt_q + 5'd1;
        sel_d = wrap ? ~sel_q : sel_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clkTop or negedge nrstTop) begin
        if (!nrstTop) begin
            fib_q <= SEED_EFF;
            gal_q <= SEED_EFF;
            cnt_q <= 5'd0;
            sel_q <= 1'b0;
        end else begin
            fib_q <= fib_d;
            gal_q <= gal_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign MUX_out = sel_q ? gal_q[4] : fib_q[4];

`ifdef LFSR_STATE_OUT_EN
    assign fib_state = fib_q;
    assign gal_state = gal_q;
    assign sel_out   = sel_q;
`endif
endmodule

// File: tb/tb_lfsr_5_top.sv
// tb_lfsr_5_top: checks lfsr_5_top against a sequence-level reference model.
module tb_lfsr_5_top;
    logic clkTop  = 1'b0;
    logic nrstTop = 1'b1;
    logic mux0, mux1, mux2;
    int   tests = 0;
    int   fails = 0;
    int   n = 0;
`ifdef LFSR_STATE_OUT_EN
    logic [4:0] fs, gs;
    logic       so;
`endif

    always #5 clkTop = ~clkTop;

    lfsr_5_top dut (
        .clkTop(clkTop), .nrstTop(nrstTop), .MUX_out(mux0)
`ifdef LFSR_STATE_OUT_EN
        , .fib_state(fs), .gal_state(gs), .sel_out(so)
`endif
    );
    lfsr_5_top #(.SEED(5'b00000), .SWITCH_LEN(1)) dut1 (
        .clkTop(clkTop), .nrstTop(nrstTop), .MUX_out(mux1)
`ifdef LFSR_STATE_OUT_EN
        , .fib_state(), .gal_state(), .sel_out()
`endif
    );
    lfsr_5_top #(.SEED(5'b10110), .SWITCH_LEN(7)) dut2 (
        .clkTop(clkTop), .nrstTop(nrstTop), .MUX_out(mux2)
`ifdef LFSR_STATE_OUT_EN
        , .fib_state(), .gal_state(), .sel_out()
`endif
    );

    // Fibonacci stream: s[k+5] = s[k] ^ s[k+2], register holds s[n..n+4] MSB first.
    function automatic logic [4:0] fib_at(logic [4:0] seed, int k);
        logic s[$];
        logic [4:0] sd;
        sd = (seed == 0) ? 5'b00001 : seed;
        for (int i = 0; i < 5; i++) s.push_back(sd[4-i]);
        for (int i = 0; i < k; i++) s.push_back(s[i] ^ s[i+2]);
        return {s[k], s[k+1], s[k+2], s[k+3], s[k+4]};
    endfunction

    // Galois register: seed * x^k reduced modulo x^5+x^2+1.
    function automatic logic [4:0] gal_at(logic [4:0] seed, int k);
        int v;
        v = (seed == 0) ? 1 : int'(seed);
        for (int i = 0; i < k; i++) begin
            v = v * 2;
            if (v >= 32) v = v ^ 37;
        end
        return 5'(v);
    endfunction

    function automatic logic exp_mux(logic [4:0] seed, int len, int k);
        logic [4:0] f, g;
        f = fib_at(seed, k);
        g = gal_at(seed, k);
        return ((k / len) % 2 == 1) ? g[4] : f[4];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_all(string ph);
        check({ph, ":mux"}, 32'(mux0), 32'(exp_mux(5'b00001, 31, n)));
        check({ph, ":mux_seed0_len1"}, 32'(mux1), 32'(exp_mux(5'b00000, 1, n)));
        check({ph, ":mux_len7"}, 32'(mux2), 32'(exp_mux(5'b10110, 7, n)));
        check({ph, ":fib"}, 32'(dut.fib_q), 32'(fib_at(5'b00001, n)));
        check({ph, ":gal"}, 32'(dut.gal_q), 32'(gal_at(5'b00001, n)));
        check({ph, ":sel"}, 32'(dut.sel_q), 32'((n / 31) % 2));
        check({ph, ":cnt"}, 32'(dut.cnt_q), 32'(n % 31));
`ifdef LFSR_STATE_OUT_EN
        check({ph, ":fib_state"}, 32'(fs), 32'(fib_at(5'b00001, n)));
        check({ph, ":gal_state"}, 32'(gs), 32'(gal_at(5'b00001, n)));
        check({ph, ":sel_out"}, 32'(so), 32'((n / 31) % 2));
`endif
    endtask

    task automatic step(string ph);
        @(posedge clkTop);
        #1;
        n++;
        check_all(ph);
    endtask

    task automatic async_reset();
        #($urandom_range(1, 3));
        nrstTop = 1'b0;
        #1;
        n = 0;
        check_all("async_rst");
        @(negedge clkTop);
        nrstTop = 1'b1;
    endtask

    initial begin
        #1 nrstTop = 1'b0;
        #1 check_all("reset_noclk");
        repeat (3) @(posedge clkTop);
        #1 check_all("reset_held");
        @(negedge clkTop);
        nrstTop = 1'b1;
        repeat (40) step("run40");
        async_reset();
        repeat (130) step("run130");
        for (int r = 0; r < 4; r++) begin
            async_reset();
            repeat ($urandom_range(5, 100)) step("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
